vx_stream_scatter: RTL and testbench
====================================

VX_STREAM_SCATTER -- requirements
Module: VX_stream_scatter

Interface
REQ-001 SHALL have parameter N, default 1: number of output lanes, N >= 1.
REQ-002 SHALL have parameter DATAW, default 1: payload width in bits.
REQ-003 SHALL have parameter REVERSE, default 0: 0 = lane 0 highest priority; 1 = lane N-1 highest.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port valid_in, input, 1: input beat present.
REQ-007 SHALL have port data_in, input, DATAW: input payload.
REQ-008 SHALL have port ready_in, output, 1: input beat accepted this cycle when high with valid_in.
REQ-009 SHALL have port lane_mask, input, N: lane i eligible for new beats only when bit i is high.
REQ-010 SHALL have port valid_out, output, N: lane i holds a beat.
REQ-011 SHALL have port data_out, output, N x DATAW: per-lane payload.
REQ-012 SHALL have port ready_out, input, N: lane i consumer accepts this cycle.
REQ-013 SHALL have port sel_out, output, max(1,$clog2(N)): lane index chosen for the current input beat; valid only when valid_in & ready_in.
REQ-014 SHALL have port occupancy, output, $clog2(N+1): number of lanes with valid_out high.

Function
REQ-015 Each lane SHALL own one register slot (valid bit + DATAW payload); valid_out/data_out SHALL be driven directly from that slot.
REQ-016 Lane i SHALL be free in a cycle when lane_mask[i]=1 and (slot empty, or valid_out[i] & ready_out[i]).
REQ-017 ready_in SHALL equal OR of free over all lanes; it SHALL NOT depend on valid_in.
REQ-018 The selected lane SHALL be the highest-priority free lane per REVERSE; sel_out SHALL report its index.
REQ-019 On valid_in & ready_in, data_in SHALL be written into the selected slot and its valid set at the next edge; latency in to out = 1 cycle.
REQ-020 Exactly one lane SHALL be written per accepted beat; no beat SHALL be duplicated or dropped.
REQ-021 On valid_out[i] & ready_out[i] with no refill of lane i, slot i valid SHALL clear at the next edge.
REQ-022 Drain and refill of the same lane in one cycle SHALL leave the slot valid with the new payload.
REQ-023 Held data_out[i] SHALL remain stable while valid_out[i] & !ready_out[i].
REQ-024 Clearing lane_mask[i] SHALL NOT flush or alter an occupied slot i; it only blocks new writes.
REQ-025 lane_mask all zero or all slots full and none draining SHALL force ready_in = 0.
REQ-026 occupancy SHALL be a registered popcount of slot valids, updated the same edge as the slots.
REQ-027 N = 1 SHALL degenerate to a single-entry pipe register with sel_out = 0.

Reset
REQ-028 On reset, all slot valid bits SHALL clear: valid_out = 0, occupancy = 0, ready_in follows lane_mask the next cycle.
REQ-029 Payload registers SHALL NOT require reset; data_out SHALL be don't-care while valid_out low.
REQ-030 Reset asserted mid-transfer SHALL discard all held and incoming beats; a beat presented during reset SHALL NOT be captured.

Structure
REQ-031 No shared-package typedefs SHALL be required; index and count widths SHALL be local parameters derived from N.
REQ-032 Free-lane selection SHALL be a sub-module VX_priority_encoder (N inputs, REVERSE, one-hot and index outputs, valid out).
REQ-033 Implementation SHALL target 120-400 lines of RTL, with no latches and no combinational path from valid_in to ready_in.

Verification
REQ-034 N=4, REVERSE=0, mask=4'b1111, all ready_out=0, 4 beats A..D -> lanes 0..3 hold A..D, occupancy=4, 5th beat sees ready_in=0.
REQ-035 N=4, REVERSE=1, empty, one beat 0x5A -> sel_out=3, next cycle valid_out=4'b1000, data_out[3]=0x5A.
REQ-036 N=4 full, ready_out[2]=1 same cycle as beat 0x33 -> sel_out=2, lane 2 drains old and holds 0x33 next cycle, occupancy stays 4.
REQ-037 N=4, mask=4'b0100, empty, 3 beats with ready_out=0 -> only first accepted into lane 2; ready_in=0 after.
REQ-038 Random valid_in/ready_out/mask for 10k cycles -> scoreboard: every accepted beat appears on exactly one lane, order per lane preserved, stable-while-stalled holds.
REQ-039 Reset asserted with 3 lanes full and valid_in=1 -> next cycle valid_out=0, occupancy=0, no beat captured.

Source files
------------

// File: rtl/vx_stream_scatter_pkg.sv
// Shared helpers for the stream scatter block.
// Index widths derive from the lane count and stay at least one bit.
package vx_stream_scatter_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_priority_encoder.sv
// Fixed-priority encoder returning one-hot grant, index and any-set flag.
// REVERSE=0 favours bit 0, REVERSE=1 favours bit N-1.
module vx_priority_encoder
    import vx_stream_scatter_pkg::*;
#(
    parameter int N       = 1,
    parameter bit REVERSE = 1'b0,
    localparam int IDXW   = idx_width(N)
) (
    input  logic [N-1:0]    data_in,
    output logic [N-1:0]    onehot_out,
    output logic [IDXW-1:0] index_out,
    output logic            valid_out
);

    // Walk from lowest to highest priority so the last hit wins.
    function automatic int pos(input int k);
        return (REVERSE != 1'b0) ? k : (N - 1 - k);
    endfunction

    always_comb begin
        onehot_out = '0;
        index_out  = '0;
        valid_out  = |data_in;
        for (int k = 0; k < N; k++) begin
            if (data_in[pos(k)]) begin
                onehot_out         = '0;
                onehot_out[pos(k)] = 1'b1;
                index_out          = IDXW'(pos(k));
            end
        end
    end

endmodule

// File: rtl/vx_stream_scatter.sv
// Scatters one input stream across N single-slot output lanes.
// Each beat lands in the highest-priority lane that is enabled and free.
module vx_stream_scatter
    import vx_stream_scatter_pkg::*;
#(
    parameter int N       = 1,
    parameter int DATAW   = 1,
    parameter bit REVERSE = 1'b0,
    localparam int IDXW   = idx_width(N),
    localparam int CNTW   = $clog2(N + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    input  logic [DATAW-1:0]          data_in,
    output logic                      ready_in,
    input  logic [N-1:0]              lane_mask,
    output logic [N-1:0]              valid_out,
    output logic [N-1:0][DATAW-1:0]   data_out,
    input  logic [N-1:0]              ready_out,
    output logic [IDXW-1:0]           sel_out,
    output logic [CNTW-1:0]           occupancy
);

    logic [N-1:0]            slot_valid;
    logic [N-1:0][DATAW-1:0] slot_data;
    logic [CNTW-1:0]         count;
    logic [CNTW-1:0]         count_next;
    logic [N-1:0]            drain;
    logic [N-1:0]            free;
    logic [N-1:0]            grant;
    logic [N-1:0]            write;
    logic [N-1:0]            valid_next;
    logic                    any_free;

    // A lane draining this cycle can take a new beat at the same edge.
    assign drain      = slot_valid & ready_out;
    assign free       = lane_mask & (~slot_valid | drain);
    assign write      = grant & {N{valid_in & any_free}};
    assign valid_next = (slot_valid & ~drain) | write;

    vx_priority_encoder #(
        .N       (N),
        .REVERSE (REVERSE)
    ) u_sel (
        .data_in    (free),
        .onehot_out (grant),
        .index_out  (sel_out),
        .valid_out  (any_free)
    );

    always_comb begin
        count_next = '0;
        for (int i = 0; i < N; i++) begin
            count_next = count_next + CNTW'(valid_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= '0;
            count      <= '0;
        end else begin
            slot_valid <= valid_next;
            count      <= count_next;
        end
    end

    // Payload carries no reset; it is only meaningful under its valid bit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (write[i]) begin
                slot_data[i] <= data_in;
            end
        end
    end

    assign ready_in  = any_free;
    assign valid_out = slot_valid;
    assign data_out  = slot_data;
    assign occupancy = count;

endmodule

// File: tb/tb_vx_stream_scatter.sv
// Self-checking bench for vx_stream_scatter with a per-lane scoreboard.
// Instance a uses REVERSE=0, instance b uses REVERSE=1.
module tb_vx_stream_scatter;

    localparam int N = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic               a_valid_in = 1'b0;
    logic [DW-1:0]      a_data_in = '0;
    logic               a_ready_in;
    logic [N-1:0]       a_mask = 4'hF;
    logic [N-1:0]       a_valid_out;
    logic [N-1:0][DW-1:0] a_data_out;
    logic [N-1:0]       a_ready_out = '0;
    logic [1:0]         a_sel;
    logic [2:0]         a_occ;

    logic               b_valid_in = 1'b0;
    logic [DW-1:0]      b_data_in = '0;
    logic               b_ready_in;
    logic [N-1:0]       b_mask = 4'hF;
    logic [N-1:0]       b_valid_out;
    logic [N-1:0][DW-1:0] b_data_out;
    logic [N-1:0]       b_ready_out = '0;
    logic [1:0]         b_sel;
    logic [2:0]         b_occ;

    vx_stream_scatter #(.N(N), .DATAW(DW), .REVERSE(1'b0)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (a_valid_in),
        .data_in   (a_data_in),
        .ready_in  (a_ready_in),
        .lane_mask (a_mask),
        .valid_out (a_valid_out),
        .data_out  (a_data_out),
        .ready_out (a_ready_out),
        .sel_out   (a_sel),
        .occupancy (a_occ)
    );

    vx_stream_scatter #(.N(N), .DATAW(DW), .REVERSE(1'b1)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (b_valid_in),
        .data_in   (b_data_in),
        .ready_in  (b_ready_in),
        .lane_mask (b_mask),
        .valid_out (b_valid_out),
        .data_out  (b_data_out),
        .ready_out (b_ready_out),
        .sel_out   (b_sel),
        .occupancy (b_occ)
    );

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for instance a: one queue per lane of expected payloads.
    logic [DW-1:0] sb [N][$];
    logic [N-1:0]  m_valid;
    logic [N-1:0]  m_free;
    int            m_sel;
    bit            armed = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                for (int i = 0; i < N; i++) m_valid[i] = (sb[i].size() > 0);
                check("valid_out", 32'(a_valid_out), 32'(m_valid));
                check("occupancy", 32'(a_occ), 32'($countones(m_valid)));
                for (int i = 0; i < N; i++)
                    if (m_valid[i])
                        check("data_out", 32'(a_data_out[i]), 32'(sb[i][0]));
                m_free = a_mask & (~m_valid | (m_valid & a_ready_out));
                check("ready_in", 32'(a_ready_in), 32'(|m_free));
                m_sel = 0;
                for (int i = N - 1; i >= 0; i--) if (m_free[i]) m_sel = i;
                if (a_valid_in && (|m_free))
                    check("sel_out", 32'(a_sel), 32'(m_sel));
            end
            if (reset) begin
                for (int i = 0; i < N; i++) sb[i].delete();
                armed = 1'b1;
            end else if (armed) begin
                for (int i = 0; i < N; i++)
                    if (m_valid[i] && a_ready_out[i]) void'(sb[i].pop_front());
                if (a_valid_in && (|m_free)) sb[m_sel].push_back(a_data_in);
            end
        end
    end

    initial begin
        int total;
        repeat (2) cyc();
        reset = 1'b0;

        // Instance b: reverse priority picks lane 3 first.
        b_valid_in = 1'b1;
        b_data_in = 8'h5A;
        #3;
        check("rev_ready", 32'(b_ready_in), 32'd1);
        check("rev_sel", 32'(b_sel), 32'd3);
        cyc();
        b_data_in = 8'h6B;
        #3;
        check("rev_valid", 32'(b_valid_out), 32'b1000);
        check("rev_data3", 32'(b_data_out[3]), 32'h5A);
        check("rev_sel2", 32'(b_sel), 32'd2);
        cyc();
        b_valid_in = 1'b0;
        #3;
        check("rev_occ", 32'(b_occ), 32'd2);
        check("rev_data2", 32'(b_data_out[2]), 32'h6B);

        // Fill all four lanes in order, then a fifth beat is refused.
        for (int k = 0; k < N; k++) begin
            a_valid_in = 1'b1;
            a_data_in = 8'hA0 + 8'(k);
            #3;
            check("fill_sel", 32'(a_sel), 32'(k));
            cyc();
        end
        a_data_in = 8'hE0;
        #3;
        check("full_ready", 32'(a_ready_in), 32'd0);
        check("full_occ", 32'(a_occ), 32'd4);
        check("full_valid", 32'(a_valid_out), 32'hF);
        for (int k = 0; k < N; k++)
            check("full_data", 32'(a_data_out[k]), 32'hA0 + 32'(k));

        // Drain and refill lane 2 in one cycle.
        cyc();
        a_data_in = 8'h33;
        a_ready_out = 4'b0100;
        #3;
        check("refill_sel", 32'(a_sel), 32'd2);
        check("refill_ready", 32'(a_ready_in), 32'd1);
        cyc();
        a_valid_in = 1'b0;
        a_ready_out = '0;
        #3;
        check("refill_data", 32'(a_data_out[2]), 32'h33);
        check("refill_occ", 32'(a_occ), 32'd4);

        // Masking keeps occupied slots intact.
        a_mask = '0;
        cyc();
        #3;
        check("mask_hold", 32'(a_valid_out), 32'hF);
        check("mask_ready", 32'(a_ready_in), 32'd0);
        a_ready_out = 4'hF;
        cyc();
        a_ready_out = '0;
        #3;
        check("mask_drain", 32'(a_valid_out), 32'd0);
        check("mask_occ", 32'(a_occ), 32'd0);

        // Only lane 2 enabled: one beat lands, the rest stall.
        a_mask = 4'b0100;
        a_valid_in = 1'b1;
        a_data_in = 8'h11;
        #3;
        check("one_sel", 32'(a_sel), 32'd2);
        cyc();
        a_data_in = 8'h12;
        #3;
        check("one_block1", 32'(a_ready_in), 32'd0);
        cyc();
        a_data_in = 8'h13;
        #3;
        check("one_block2", 32'(a_ready_in), 32'd0);
        cyc();
        a_valid_in = 1'b0;
        #3;
        check("one_valid", 32'(a_valid_out), 32'b0100);
        check("one_data", 32'(a_data_out[2]), 32'h11);

        // Reset with three lanes full and a beat on the input.
        a_mask = 4'hF;
        a_ready_out = 4'hF;
        cyc();
        a_ready_out = '0;
        for (int k = 0; k < 3; k++) begin
            a_valid_in = 1'b1;
            a_data_in = 8'h40 + 8'(k);
            cyc();
        end
        a_data_in = 8'h77;
        #3;
        check("pre_rst_occ", 32'(a_occ), 32'd3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        a_valid_in = 1'b0;
        #3;
        check("rst_valid", 32'(a_valid_out), 32'd0);
        check("rst_occ", 32'(a_occ), 32'd0);
        check("rst_ready", 32'(a_ready_in), 32'd1);
        cyc();
        #3;
        check("rst_nocap", 32'(a_valid_out), 32'd0);

        // Random traffic checked by the scoreboard every cycle.
        for (int c = 0; c < 10000; c++) begin
            a_valid_in = 1'($urandom);
            a_data_in = 8'($urandom);
            a_ready_out = 4'($urandom);
            a_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            cyc();
        end
        a_valid_in = 1'b0;
        a_mask = 4'hF;
        a_ready_out = 4'hF;
        repeat (3) cyc();
        total = 0;
        for (int i = 0; i < N; i++) total += sb[i].size();
        check("sb_empty", 32'(total), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
